alu_issue_wb: RTL

//  Single-issue execute/writeback stage wrapping the combinational ALU units (add/sub/mul/div).

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_regfile.sv | 47 ++++
 rtl/alu_issue_wb.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the execute/writeback stage.
//   op_e        : operation encoding (LI=0 ADD=1 SUB=2 MUL=3 DIV=4; 5-7 illegal)
//   state_e     : issue FSM states (IDLE -> EXEC -> WB -> IDLE)
//   WIDTH_DEF   : default datapath width
//   REG_IDX_W   : register index width
//   DIV0_RESULT : value written back when a DIV has a zero divisor
//   op_legal()  : true for the five defined opcodes
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int          WIDTH_DEF   = 16;
    localparam int          REG_IDX_W   = 3;
    localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

    typedef enum logic [2:0] {
        OP_LI  = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_DIV);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NREGS x WIDTH register file, r0 hardwired to zero.
//   clk, rst          : clock, synchronous active-high reset (clears all registers)
//   we, waddr, wdata  : synchronous write port (writes to r0 are dropped)
//   raddr1 / rdata1   : combinational read port 1
//   raddr2 / rdata2   : combinational read port 2
//   dbg_addr/dbg_data : combinational debug read port
// -----------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    output logic [WIDTH-1:0]     rdata1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [WIDTH-1:0]     rdata2,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]     dbg_data
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is decoded to zero on every read port rather than relying on its
    // storage staying clear.
    assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// -----------------------------------------------------------------------------
// alu_issue_wb
// Single-issue execute/writeback stage around external combinational ALU units.
// One op is accepted per valid/ready transfer, operands are read from the
// internal register file, the op waits its settle latency in EXEC, then the
// selected unit result is written back in WB.
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE; the requester holds its fields until then.
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : op request handshake
//   in_op, in_rd, in_rs1, in_rs2   : opcode and register indices
//   in_imm                         : immediate (LI only)
//   alu_rs1, alu_rs2               : registered operands to the ALU units
//   add_res, add_co, sub_res,
//   mul_res, div_res               : ALU unit results
//   out_valid, out_rd, out_data    : one-cycle writeback report
//   flags                          : {div0, zero, carry}
//   dbg_addr, dbg_data             : combinational register file peek
//
// Build option: define ALU_ISSUE_FLAGS_EN to enable the flags register;
// otherwise flags is tied to 3'b000.
// -----------------------------------------------------------------------------
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NREGS   = 8,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [WIDTH-1:0]     in_imm,
    output logic [WIDTH-1:0]     alu_rs1,
    output logic [WIDTH-1:0]     alu_rs2,
    input  logic [WIDTH-1:0]     add_res,
    input  logic                 add_co,
    input  logic [WIDTH-1:0]     sub_res,
    input  logic [WIDTH-1:0]     mul_res,
    input  logic [WIDTH-1:0]     div_res,
    output logic                 out_valid,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           flags,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]     dbg_data
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // Counter is loaded with latency-1 so that cnt==0 marks the final EXEC cycle.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [2:0] op);
        case (op)
            OP_MUL:  return CNT_W'(MUL_LAT - 1);
            OP_DIV:  return CNT_W'(DIV_LAT - 1);
            default: return '0;
        endcase
    endfunction

    state_e               state;
    logic [2:0]           op_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic [WIDTH-1:0]     imm_q;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     rs1_data;
    logic [WIDTH-1:0]     rs2_data;
    logic [WIDTH-1:0]     result;
    logic                 div0;
    logic                 wb_we;

    // Register file: writes happen during WB, using the reported rd/data.
    // Illegal ops report out_rd=0, which the regfile treats as a dropped write.
    assign wb_we = (state == ST_WB);

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_we),
        .waddr    (out_rd),
        .wdata    (out_data),
        .raddr1   (in_rs1),
        .rdata1   (rs1_data),
        .raddr2   (in_rs2),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign div0 = (op_q == OP_DIV) && (alu_rs2 == '0);

    // Result select from the unit matching the latched op.
    always_comb begin
        result = '0;
        case (op_q)
            OP_LI:   result = imm_q;
            OP_ADD:  result = add_res;
            OP_SUB:  result = sub_res;
            OP_MUL:  result = mul_res;
            OP_DIV:  result = div0 ? WIDTH'(DIV0_RESULT) : div_res;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        op_q     <= in_op;
                        rd_q     <= in_rd;
                        imm_q    <= in_imm;
                        alu_rs1  <= rs1_data;
                        alu_rs2  <= rs2_data;
                        cnt      <= lat_m1(in_op);
                        in_ready <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        out_data  <= result;
                        out_rd    <= op_legal(op_q) ? rd_q : '0;
                        out_valid <= 1'b1;
                        state     <= ST_WB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WB: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    // Flags are captured together with out_data so they are visible during WB
    // and hold until the next writeback.
    logic [2:0] flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else if ((state == ST_EXEC) && (cnt == '0)) begin
            flags_q <= {div0,
                        (result == '0),
                        (op_q == OP_ADD) ? add_co : 1'b0};
        end
    end

    assign flags = flags_q;
`else
    logic unused_add_co;
    assign unused_add_co = add_co;
    assign flags         = 3'b000;
`endif

endmodule
